x86_opcode_encoder: RTL and testbench
=====================================

Name: x86_opcode_encoder

Overview:
- Inverse of the decoder's opcode-map lookup: takes one instruction descriptor and serializes its x86-64 bytes, one byte per cycle.
- Byte order: optional REX, escape bytes (0F / 0F38 / 0F3A), opcode, ModRM, little-endian immediate.
- Sits ahead of the fetch/decode path as a test-stimulus and self-modifying-code byte source.
- Valid/ready handshake on both sides; holds one descriptor at a time.

Parameters:
- IMM_MAX_BYTES, 4: widest immediate supported; legal imm_len values are 0, 1, 2, 4.
- LEN_W, 4: width of the emitted-byte counter; max instruction length is 1+2+1+1+4 = 9.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  encoder idle; accepts a descriptor this cycle.
- req_map  in  3  1 = one-byte map, 2 = 0F, 3 = 0F38, 4 = 0F3A; other values are illegal.
- req_opcode  in  8  final opcode byte.
- req_has_modrm  in  1  emit a ModRM byte.
- req_modrm  in  8  ModRM byte.
- req_is_group  in  1  group opcode; replace modrm[5:3] with req_group_reg.
- req_group_reg  in  3  group sub-opcode (/digit).
- req_imm_len  in  3  immediate byte count.
- req_imm  in  32  immediate; emitted LSB first.
- req_rex  in  8  REX byte; used only when OPCODE_ENC_REX_EN is defined.
- req_rex_valid  in  1  emit REX.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  consumer accepts the byte.
- out_byte  out  8  current byte.
- out_last  out  1  current byte is the final byte of the instruction.
- out_len  out  LEN_W  total instruction length; valid while out_last=1.
- err  out  1  one-cycle pulse: illegal descriptor dropped.

Behaviour:
- Reset values: req_ready=1, out_valid=0, out_byte=0, out_last=0, out_len=0, err=0, state=IDLE, all counters 0.
- Reset asserted mid-instruction aborts it; nothing further is emitted.
- Accept: req_valid & req_ready on edge N latches the whole descriptor and drops req_ready. The first byte presents out_valid=1 in cycle N+1.
- Illegal descriptor: req_map not in 1..4, or req_imm_len not in {0,1,2,4}.
  - Not latched; err pulses for 1 cycle in cycle N+1.
  - State stays IDLE; req_ready stays 1.
- Group fold: when req_is_group=1, the latched ModRM is {modrm[7:6], group_reg, modrm[2:0]}. This is applied at accept time.
- FSM states: IDLE, REX, ESC0, ESC1, OPC, MODRM, IMM.
- Entry from IDLE goes to the first applicable state in this order: REX (if enabled and rex_valid), ESC0 (map≥2), OPC.
- State bytes and exits:
  - REX emits req_rex, then goes to ESC0 if map≥2, else OPC.
  - ESC0 emits 0F, then goes to ESC1 if map≥3, else OPC.
  - ESC1 emits 38 for map 3 or 3A for map 4, then goes to OPC.
  - OPC emits opcode, then goes to MODRM if has_modrm, else IMM if imm_len≠0, else done.
  - MODRM emits the folded ModRM, then goes to IMM or done.
  - IMM emits imm[8k+7:8k] for k = 0..imm_len-1; a byte counter compares against imm_len-1.
- Advance rule: a state advances only on out_valid & out_ready. While out_ready=0, out_byte, out_last and out_len hold stable.
- No combinational path from out_ready to out_valid.
- out_last=1 on the final byte; out_len equals the count of emitted bytes, including the final one.
- Done: the final handshake returns state to IDLE and sets req_ready=1 in the next cycle. A new descriptor is accepted the cycle after that, so there is one bubble between instructions (no back-to-back overlap).
- Byte-count width: LEN_W must be ≥4; the counter never wraps for legal input.

Optional Feature:
- Macro: OPCODE_ENC_REX_EN.
- Defined: when req_rex_valid=1, the REX byte is emitted first. req_rex[7:4] must equal 4; otherwise the descriptor is illegal and err pulses.
- Undefined: the REX state is not generated; req_rex and req_rex_valid are ignored and left unused with a lint waiver. Maximum length is 8.

Decomposition:
- DecoderTypes package gains:
  - enc_req_t: packed descriptor struct.
  - enc_state_t: FSM enum.
  - Constants ESC_0F='h0F, ESC_38='h38, ESC_3A='h3A.
  - Map IDs MAP_1B..MAP_0F3A.
- Single module; no sub-module is warranted. The ModRM group fold is a local automatic function.

Test Plan:
- add Ev_Gv: map=1, op=01, modrm=D8, imm_len=0, out_ready=1 → bytes 01, D8; out_last on D8; out_len=2.
- jz Jz: map=2, op=84, no modrm, imm_len=4, imm=00000010 → 0F 84 10 00 00 00; out_len=6.
- Group 1 sub: map=1, op=83, is_group=1, modrm=C0, group_reg=5, imm_len=1, imm=07 → 83 E8 07.
- Backpressure: on the jz case, drop out_ready for 3 cycles at byte 84 → 84 held stable; total still 6 bytes in order; req_ready=0 throughout.
- Illegal: map=0 or imm_len=3 → err=1 for exactly 1 cycle; no out_valid; req_ready remains 1. Assert reset mid-stream after the 0F byte → next cycle out_valid=0, req_ready=1.
- REX (macro defined): rex=48, map=1, op=89, modrm=E5 → 48 89 E5; rex=38 → err pulse.

Source files
------------

// File: rtl/x86_opcode_encoder_pkg.sv
// x86_opcode_encoder_pkg
// Shared types and constants for the x86-64 opcode byte serializer.
//   - enc_req_t   : descriptor latched by the encoder while it emits bytes
//   - enc_state_t : encoder FSM states, in emission order
//   - ESC_*       : escape bytes that select the 0F / 0F38 / 0F3A maps
//   - MAP_*       : map identifiers carried on req_map
// The REX portion of a descriptor is held outside enc_req_t because it only
// exists when OPCODE_ENC_REX_EN is defined.
package x86_opcode_encoder_pkg;

  localparam logic [2:0] MAP_1B   = 3'd1;
  localparam logic [2:0] MAP_0F   = 3'd2;
  localparam logic [2:0] MAP_0F38 = 3'd3;
  localparam logic [2:0] MAP_0F3A = 3'd4;

  localparam logic [7:0] ESC_0F = 8'h0F;
  localparam logic [7:0] ESC_38 = 8'h38;
  localparam logic [7:0] ESC_3A = 8'h3A;

  typedef enum logic [2:0] {
    IDLE,
    REX,
    ESC0,
    ESC1,
    OPC,
    MODRM,
    IMM
  } enc_state_t;

  typedef struct packed {
    logic [2:0]  map;
    logic [7:0]  opcode;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic [2:0]  imm_len;
    logic [31:0] imm;
  } enc_req_t;

  // Immediates are only ever 0, 1, 2 or 4 bytes wide in the encodings we emit.
  function automatic logic imm_len_legal(input logic [2:0] len);
    return (len == 3'd0) || (len == 3'd1) || (len == 3'd2) || (len == 3'd4);
  endfunction

  function automatic logic map_legal(input logic [2:0] map);
    return (map >= MAP_1B) && (map <= MAP_0F3A);
  endfunction

endpackage

// File: rtl/x86_opcode_encoder.sv
// x86_opcode_encoder
// Serializes one instruction descriptor into its x86-64 byte stream, one byte
// per cycle: [REX] [0F [38|3A]] opcode [ModRM] [imm, little-endian].
//
// Configuration macro: OPCODE_ENC_REX_EN
//   defined   : req_rex is emitted first when req_rex_valid=1; a REX byte whose
//               upper nibble is not 4 makes the descriptor illegal.
//   undefined : no REX state; req_rex / req_rex_valid are ignored.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   req_valid/ready : descriptor handshake (ready only while idle)
//   req_*           : descriptor fields (map, opcode, ModRM, group digit,
//                     immediate length/value, REX)
//   out_valid/ready : byte stream handshake
//   out_byte        : byte being presented
//   out_last        : out_byte is the final byte of the instruction
//   out_len         : total instruction length, valid while out_last=1
//   err             : one-cycle pulse when an illegal descriptor is dropped
module x86_opcode_encoder
  import x86_opcode_encoder_pkg::*;
#(
  parameter int IMM_MAX_BYTES = 4,
  parameter int LEN_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_map,
  input  logic [7:0]       req_opcode,
  input  logic             req_has_modrm,
  input  logic [7:0]       req_modrm,
  input  logic             req_is_group,
  input  logic [2:0]       req_group_reg,
  input  logic [2:0]       req_imm_len,
  input  logic [31:0]      req_imm,
  input  logic [7:0]       req_rex,
  input  logic             req_rex_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [LEN_W-1:0] out_len,
  output logic             err
);

  localparam logic [2:0] IMM_MAX_L = 3'(IMM_MAX_BYTES);

  enc_state_t       state;
  enc_state_t       state_next;
  enc_req_t         desc;
  logic [1:0]       imm_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic             accept;
  logic             illegal;
  logic             fire;
  enc_state_t       first_state;

`ifdef OPCODE_ENC_REX_EN
  logic [7:0] rex_q;
  logic       rex_valid_q;
`else
  logic unused_rex;
  assign unused_rex = ^{req_rex, req_rex_valid};
`endif

  // Group opcodes carry their sub-opcode in ModRM.reg; fold it in once at
  // accept so the MODRM state just replays a stored byte.
  function automatic logic [7:0] fold_modrm(input logic [7:0] modrm,
                                            input logic       is_group,
                                            input logic [2:0] group_reg);
    return is_group ? {modrm[7:6], group_reg, modrm[2:0]} : modrm;
  endfunction

  assign req_ready = (state == IDLE);
  assign out_valid = (state != IDLE);
  assign accept    = req_valid & req_ready;
  assign fire      = out_valid & out_ready;

  always_comb begin
    illegal = !map_legal(req_map) || !imm_len_legal(req_imm_len) ||
              (req_imm_len > IMM_MAX_L);
`ifdef OPCODE_ENC_REX_EN
    if (req_rex_valid && (req_rex[7:4] != 4'h4)) begin
      illegal = 1'b1;
    end
`endif
  end

  // Entry point out of IDLE depends on the incoming descriptor, not the
  // latched one, since the latch happens on the same edge.
  always_comb begin
    first_state = OPC;
    if (req_map != MAP_1B) begin
      first_state = ESC0;
    end
`ifdef OPCODE_ENC_REX_EN
    if (req_rex_valid) begin
      first_state = REX;
    end
`endif
  end

  // out_last depends only on registered state, so out_byte/out_last/out_len
  // hold steady under backpressure and out_valid never sees out_ready.
  always_comb begin
    out_byte = 8'h00;
    out_last = 1'b0;
    case (state)
`ifdef OPCODE_ENC_REX_EN
      REX:   out_byte = rex_q;
`endif
      ESC0:  out_byte = ESC_0F;
      ESC1:  out_byte = (desc.map == MAP_0F38) ? ESC_38 : ESC_3A;
      OPC: begin
        out_byte = desc.opcode;
        out_last = !desc.has_modrm && (desc.imm_len == 3'd0);
      end
      MODRM: begin
        out_byte = desc.modrm;
        out_last = (desc.imm_len == 3'd0);
      end
      IMM: begin
        out_byte = desc.imm[{imm_cnt, 3'b000} +: 8];
        out_last = ({1'b0, imm_cnt} == (desc.imm_len - 3'd1));
      end
      default: begin
        out_byte = 8'h00;
        out_last = 1'b0;
      end
    endcase
  end

  assign out_len = out_last ? (byte_cnt + LEN_W'(1)) : '0;

  // Next-state: every non-idle state moves only on a byte handshake, and the
  // final handshake of any state returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !illegal) begin
          state_next = first_state;
        end
      end
      REX: begin
        if (fire) begin
          state_next = (desc.map != MAP_1B) ? ESC0 : OPC;
        end
      end
      ESC0: begin
        if (fire) begin
          state_next = (desc.map != MAP_0F) ? ESC1 : OPC;
        end
      end
      ESC1: begin
        if (fire) begin
          state_next = OPC;
        end
      end
      OPC: begin
        if (fire) begin
          if (desc.has_modrm) begin
            state_next = MODRM;
          end else if (desc.imm_len != 3'd0) begin
            state_next = IMM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      MODRM: begin
        if (fire) begin
          state_next = (desc.imm_len != 3'd0) ? IMM : IDLE;
        end
      end
      IMM: begin
        if (fire && out_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, descriptor latch, byte counters and the err pulse.
  // Illegal descriptors never touch the latch; err simply pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      desc     <= '0;
      imm_cnt  <= '0;
      byte_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      err   <= accept & illegal;
      if (accept && !illegal) begin
        desc.map       <= req_map;
        desc.opcode    <= req_opcode;
        desc.has_modrm <= req_has_modrm;
        desc.modrm     <= fold_modrm(req_modrm, req_is_group, req_group_reg);
        desc.imm_len   <= req_imm_len;
        desc.imm       <= req_imm;
        imm_cnt        <= '0;
        byte_cnt       <= '0;
      end else if (fire) begin
        byte_cnt <= byte_cnt + LEN_W'(1);
        if (state == IMM) begin
          imm_cnt <= imm_cnt + 2'd1;
        end
      end
    end
  end

`ifdef OPCODE_ENC_REX_EN
  // REX is latched separately so the default build carries no dead bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      rex_q       <= 8'h00;
      rex_valid_q <= 1'b0;
    end else if (accept && !illegal) begin
      rex_q       <= req_rex;
      rex_valid_q <= req_rex_valid;
    end
  end

  logic unused_rex_valid;
  assign unused_rex_valid = rex_valid_q;
`endif

endmodule

// File: tb/tb_x86_opcode_encoder.sv
// tb_x86_opcode_encoder
// Directed plus randomized stimulus for x86_opcode_encoder. Expected byte
// streams come from a list-building model of the x86 encoding rules.
// Honors OPCODE_ENC_REX_EN the same way as the design.
module tb_x86_opcode_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_map;
  logic [7:0]  req_opcode;
  logic        req_has_modrm;
  logic [7:0]  req_modrm;
  logic        req_is_group;
  logic [2:0]  req_group_reg;
  logic [2:0]  req_imm_len;
  logic [31:0] req_imm;
  logic [7:0]  req_rex;
  logic        req_rex_valid;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [3:0]  out_len;
  logic        err;

  int checks = 0;
  int passes = 0;
  logic [7:0] expQ[$];
  logic       expLegal;

  x86_opcode_encoder #(.IMM_MAX_BYTES(4), .LEN_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_map(req_map), .req_opcode(req_opcode),
    .req_has_modrm(req_has_modrm), .req_modrm(req_modrm),
    .req_is_group(req_is_group), .req_group_reg(req_group_reg),
    .req_imm_len(req_imm_len), .req_imm(req_imm),
    .req_rex(req_rex), .req_rex_valid(req_rex_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last), .out_len(out_len),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: the instruction is a list of bytes built prefix-first.
  task automatic modelEncode();
    logic [7:0] m;
    expQ.delete();
    expLegal = (req_map >= 1) && (req_map <= 4) &&
               (req_imm_len == 0 || req_imm_len == 1 ||
                req_imm_len == 2 || req_imm_len == 4);
`ifdef OPCODE_ENC_REX_EN
    if (req_rex_valid) begin
      if ((req_rex >> 4) != 8'd4) expLegal = 1'b0;
      expQ.push_back(req_rex);
    end
`endif
    if (req_map >= 2) expQ.push_back(8'h0F);
    if (req_map == 3) expQ.push_back(8'h38);
    if (req_map == 4) expQ.push_back(8'h3A);
    expQ.push_back(req_opcode);
    if (req_has_modrm) begin
      m = req_modrm;
      if (req_is_group) m = (req_modrm & 8'hC7) | 8'({req_group_reg} * 8);
      expQ.push_back(m);
    end
    for (int k = 0; k < int'(req_imm_len); k++)
      expQ.push_back(8'((req_imm >> (8 * k)) & 32'hFF));
  endtask

  task automatic setDescriptor(input logic [2:0] map, input logic [7:0] op,
                               input logic hm, input logic [7:0] modrm,
                               input logic grp, input logic [2:0] greg,
                               input logic [2:0] ilen, input logic [31:0] imm,
                               input logic [7:0] rex, input logic rexv);
    req_map = map; req_opcode = op; req_has_modrm = hm; req_modrm = modrm;
    req_is_group = grp; req_group_reg = greg; req_imm_len = ilen;
    req_imm = imm; req_rex = rex; req_rex_valid = rexv;
  endtask

  // Presents the current descriptor and returns in the cycle after accept.
  task automatic applyStimulus();
    int w = 0;
    req_valid = 1'b1;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles on byte index 1
  task automatic drainOutput(input int mode);
    int idx = 0;
    int stall = 0;
    int cyc = 0;
    logic rdy;
    int n = expQ.size();
    checkOutput("first_valid", 32'(out_valid), 32'd1);
    while (idx < n && cyc < 64) begin
      if (out_valid) begin
        checkOutput("byte", 32'(out_byte), 32'(expQ[idx]));
        checkOutput("last", 32'(out_last), 32'(idx == n - 1));
        if (idx == n - 1) checkOutput("len", 32'(out_len), 32'(n));
        checkOutput("busy_ready", 32'(req_ready), 32'd0);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = 1'b1;
          if (idx == 1 && stall < 3) begin
            rdy = 1'b0;
            stall++;
          end
        end
      endcase
      out_ready = rdy;
      if (out_valid && rdy) idx++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput("drain_count", 32'(idx), 32'(n));
    checkOutput("done_valid", 32'(out_valid), 32'd0);
    checkOutput("done_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic runDescriptor(input int mode);
    modelEncode();
    applyStimulus();
    if (expLegal) begin
      checkOutput("no_err", 32'(err), 32'd0);
      drainOutput(mode);
    end else begin
      checkOutput("err_pulse", 32'(err), 32'd1);
      checkOutput("err_no_valid", 32'(out_valid), 32'd0);
      checkOutput("err_ready", 32'(req_ready), 32'd1);
      tick();
      checkOutput("err_one_cycle", 32'(err), 32'd0);
      checkOutput("err_still_idle", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [2:0] lenTable[5];
    lenTable = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3};
    reset = 1'b1;
    req_valid = 1'b0;
    out_ready = 1'b0;
    setDescriptor(3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 32'd0, 8'h00, 1'b0);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_byte", 32'(out_byte), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_len", 32'(out_len), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] directed encodings");
    setDescriptor(3'd1, 8'h01, 1'b1, 8'hD8, 1'b0, 3'd0, 3'd0, 32'd0, 8'h00, 1'b0);
    runDescriptor(0);
    setDescriptor(3'd2, 8'h84, 1'b0, 8'h00, 1'b0, 3'd0, 3'd4, 32'h10, 8'h00, 1'b0);
    runDescriptor(0);
    setDescriptor(3'd1, 8'h83, 1'b1, 8'hC0, 1'b1, 3'd5, 3'd1, 32'h07, 8'h00, 1'b0);
    runDescriptor(0);
    setDescriptor(3'd2, 8'h84, 1'b0, 8'h00, 1'b0, 3'd0, 3'd4, 32'h10, 8'h00, 1'b0);
    runDescriptor(2);
    setDescriptor(3'd4, 8'h0F, 1'b1, 8'h12, 1'b0, 3'd0, 3'd2, 32'hBEEF, 8'h00, 1'b0);
    runDescriptor(1);

    $display("[TB] illegal descriptors");
    setDescriptor(3'd0, 8'h90, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 32'd0, 8'h00, 1'b0);
    runDescriptor(0);
    setDescriptor(3'd1, 8'h90, 1'b0, 8'h00, 1'b0, 3'd0, 3'd3, 32'd0, 8'h00, 1'b0);
    runDescriptor(0);

`ifdef OPCODE_ENC_REX_EN
    $display("[TB] REX prefix");
    setDescriptor(3'd1, 8'h89, 1'b1, 8'hE5, 1'b0, 3'd0, 3'd0, 32'd0, 8'h48, 1'b1);
    runDescriptor(0);
    setDescriptor(3'd1, 8'h89, 1'b1, 8'hE5, 1'b0, 3'd0, 3'd0, 32'd0, 8'h38, 1'b1);
    runDescriptor(0);
`endif

    $display("[TB] reset mid-stream");
    setDescriptor(3'd2, 8'h84, 1'b0, 8'h00, 1'b0, 3'd0, 3'd4, 32'h10, 8'h00, 1'b0);
    applyStimulus();
    checkOutput("mid_esc", 32'(out_byte), 32'h0F);
    out_ready = 1'b1;
    tick();
    checkOutput("mid_opc", 32'(out_byte), 32'h84);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    tick();
    checkOutput("abort_stays", 32'(out_valid), 32'd0);

    $display("[TB] randomized descriptors");
    for (int t = 0; t < 40; t++) begin
      setDescriptor(($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                                : 3'($urandom_range(1, 4)),
                    8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                    3'($urandom), lenTable[$urandom_range(0, 4)], $urandom,
                    ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                                : {4'h4, 4'($urandom)},
                    1'($urandom));
      runDescriptor(1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
